// File: rtl/decoder_3r_stage_pkg.sv
// Shared types and encodings for the 3R-type decode stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decoder_3r_stage_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int GPR_NUM       = 32;
  localparam int REG_AW        = $clog2(GPR_NUM);
  localparam int ALU_OP_WIDTH  = 8;
  localparam int ALU_SEL_WIDTH = 3;
  localparam int OPC_WIDTH     = 17;

  // One entry from the instruction buffer
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } instr_buffer_info_t;

  // Decoded 3R instruction handed to dispatch
  typedef struct packed {
    logic                     decode_valid;
    logic [1:0]               reg_read_valid;
    logic [2*REG_AW-1:0]      reg_read_addr;   // {rk, rj}
    logic                     reg_write_valid;
    logic [REG_AW-1:0]        reg_write_addr;
    logic [ALU_OP_WIDTH-1:0]  aluop;
    logic [ALU_SEL_WIDTH-1:0] alusel;
    logic                     use_imm;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     instr_break;
    logic                     instr_syscall;
    logic                     is_pri;
    logic                     not_commit_instr;
    logic [ADDR_WIDTH-1:0]    pc;
  } decode_3r_result_t;

  // 3R major opcodes, instr[31:15]
  localparam logic [OPC_WIDTH-1:0] OPC_ADD_W   = 17'h00020;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB_W   = 17'h00022;
  localparam logic [OPC_WIDTH-1:0] OPC_SLT     = 17'h00024;
  localparam logic [OPC_WIDTH-1:0] OPC_SLTU    = 17'h00025;
  localparam logic [OPC_WIDTH-1:0] OPC_NOR     = 17'h00028;
  localparam logic [OPC_WIDTH-1:0] OPC_AND     = 17'h00029;
  localparam logic [OPC_WIDTH-1:0] OPC_OR      = 17'h0002A;
  localparam logic [OPC_WIDTH-1:0] OPC_XOR     = 17'h0002B;
  localparam logic [OPC_WIDTH-1:0] OPC_SLL_W   = 17'h0002E;
  localparam logic [OPC_WIDTH-1:0] OPC_SRL_W   = 17'h0002F;
  localparam logic [OPC_WIDTH-1:0] OPC_SRA_W   = 17'h00030;
  localparam logic [OPC_WIDTH-1:0] OPC_MUL_W   = 17'h00038;
  localparam logic [OPC_WIDTH-1:0] OPC_MULH_W  = 17'h00039;
  localparam logic [OPC_WIDTH-1:0] OPC_MULH_WU = 17'h0003A;
  localparam logic [OPC_WIDTH-1:0] OPC_DIV_W   = 17'h00040;
  localparam logic [OPC_WIDTH-1:0] OPC_MOD_W   = 17'h00041;
  localparam logic [OPC_WIDTH-1:0] OPC_DIV_WU  = 17'h00042;
  localparam logic [OPC_WIDTH-1:0] OPC_MOD_WU  = 17'h00043;
  localparam logic [OPC_WIDTH-1:0] OPC_BREAK   = 17'h00054;
  localparam logic [OPC_WIDTH-1:0] OPC_SYSCALL = 17'h00056;
  localparam logic [OPC_WIDTH-1:0] OPC_IDLE    = 17'h00C91;
  localparam logic [OPC_WIDTH-1:0] OPC_INVTLB  = 17'h00C93;
  localparam logic [OPC_WIDTH-1:0] OPC_DBAR    = 17'h070E4;
  localparam logic [OPC_WIDTH-1:0] OPC_IBAR    = 17'h070E5;

  // SYSCALL code the simulator uses as its stop marker
  localparam logic [14:0] NEMU_STOP_CODE = 15'h0011;

  // Execute operation codes
  localparam logic [ALU_OP_WIDTH-1:0] EXE_NOP_OP     = 8'h00;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_ADD_OP     = 8'h01;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SUB_OP     = 8'h02;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SLT_OP     = 8'h03;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SLTU_OP    = 8'h04;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_NOR_OP     = 8'h05;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_AND_OP     = 8'h06;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_OR_OP      = 8'h07;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_XOR_OP     = 8'h08;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SLL_OP     = 8'h09;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SRL_OP     = 8'h0A;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SRA_OP     = 8'h0B;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_MUL_OP     = 8'h0C;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_MULH_OP    = 8'h0D;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_MULHU_OP   = 8'h0E;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_DIV_OP     = 8'h0F;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_MOD_OP     = 8'h10;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_DIVU_OP    = 8'h11;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_MODU_OP    = 8'h12;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_BREAK_OP   = 8'h13;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_SYSCALL_OP = 8'h14;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_IDLE_OP    = 8'h15;
  localparam logic [ALU_OP_WIDTH-1:0] EXE_INVTLB_OP  = 8'h16;

  // Result-select codes
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_NOP   = 3'd0;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_ARITH = 3'd3;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_MUL   = 3'd4;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_DIV   = 3'd5;
  localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_PRIV  = 3'd6;

endpackage

// File: rtl/decoder_3r_stage_lane.sv
// Single-instruction combinational decoder for 3R-type instructions.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when results are taken.
module decoder_3r_lane
  import decoder_3r_stage_pkg::*;
#(
  parameter bit NEMU_STOP_SYSCALL = 1'b1
) (
  input  instr_buffer_info_t i_info,
  output decode_3r_result_t  o_result
);

  logic [OPC_WIDTH-1:0] w_opcode;
  logic [REG_AW-1:0]    w_rk;
  logic [REG_AW-1:0]    w_rj;
  logic [REG_AW-1:0]    w_rd;
  logic [14:0]          w_code;
  logic                 w_alu;

  assign w_opcode = i_info.instr[31:15];
  assign w_rk     = i_info.instr[14:10];
  assign w_rj     = i_info.instr[9:5];
  assign w_rd     = i_info.instr[4:0];
  assign w_code   = i_info.instr[14:0];

  // Opcode lookup; ALU ops share the {rk,rj}->rd register pattern applied at the end
  always_comb begin
    o_result              = '0;
    o_result.pc           = i_info.pc;
    o_result.decode_valid = 1'b1;
    w_alu                 = 1'b1;
    case (w_opcode)
      OPC_ADD_W:   begin o_result.aluop = EXE_ADD_OP;   o_result.alusel = EXE_RES_ARITH; end
      OPC_SUB_W:   begin o_result.aluop = EXE_SUB_OP;   o_result.alusel = EXE_RES_ARITH; end
      OPC_SLT:     begin o_result.aluop = EXE_SLT_OP;   o_result.alusel = EXE_RES_ARITH; end
      OPC_SLTU:    begin o_result.aluop = EXE_SLTU_OP;  o_result.alusel = EXE_RES_ARITH; end
      OPC_NOR:     begin o_result.aluop = EXE_NOR_OP;   o_result.alusel = EXE_RES_LOGIC; end
      OPC_AND:     begin o_result.aluop = EXE_AND_OP;   o_result.alusel = EXE_RES_LOGIC; end
      OPC_OR:      begin o_result.aluop = EXE_OR_OP;    o_result.alusel = EXE_RES_LOGIC; end
      OPC_XOR:     begin o_result.aluop = EXE_XOR_OP;   o_result.alusel = EXE_RES_LOGIC; end
      OPC_SLL_W:   begin o_result.aluop = EXE_SLL_OP;   o_result.alusel = EXE_RES_SHIFT; end
      OPC_SRL_W:   begin o_result.aluop = EXE_SRL_OP;   o_result.alusel = EXE_RES_SHIFT; end
      OPC_SRA_W:   begin o_result.aluop = EXE_SRA_OP;   o_result.alusel = EXE_RES_SHIFT; end
      OPC_MUL_W:   begin o_result.aluop = EXE_MUL_OP;   o_result.alusel = EXE_RES_MUL;   end
      OPC_MULH_W:  begin o_result.aluop = EXE_MULH_OP;  o_result.alusel = EXE_RES_MUL;   end
      OPC_MULH_WU: begin o_result.aluop = EXE_MULHU_OP; o_result.alusel = EXE_RES_MUL;   end
      OPC_DIV_W:   begin o_result.aluop = EXE_DIV_OP;   o_result.alusel = EXE_RES_DIV;   end
      OPC_MOD_W:   begin o_result.aluop = EXE_MOD_OP;   o_result.alusel = EXE_RES_DIV;   end
      OPC_DIV_WU:  begin o_result.aluop = EXE_DIVU_OP;  o_result.alusel = EXE_RES_DIV;   end
      OPC_MOD_WU:  begin o_result.aluop = EXE_MODU_OP;  o_result.alusel = EXE_RES_DIV;   end
      OPC_BREAK: begin
        w_alu                     = 1'b0;
        o_result.aluop            = EXE_BREAK_OP;
        o_result.alusel           = EXE_RES_PRIV;
        o_result.instr_break      = 1'b1;
        o_result.is_pri           = 1'b1;
        o_result.not_commit_instr = 1'b1;
      end
      OPC_SYSCALL: begin
        w_alu = 1'b0;
        // The simulator stop marker flows through as a plain NOP
        if (!(NEMU_STOP_SYSCALL && (w_code == NEMU_STOP_CODE))) begin
          o_result.aluop            = EXE_SYSCALL_OP;
          o_result.alusel           = EXE_RES_PRIV;
          o_result.instr_syscall    = 1'b1;
          o_result.is_pri           = 1'b1;
          o_result.not_commit_instr = 1'b1;
        end
      end
      OPC_IDLE: begin
        w_alu                     = 1'b0;
        o_result.aluop            = EXE_IDLE_OP;
        o_result.alusel           = EXE_RES_PRIV;
        o_result.is_pri           = 1'b1;
        o_result.not_commit_instr = 1'b1;
      end
      OPC_DBAR, OPC_IBAR: begin
        // Barriers are no-ops in an in-order backend
        w_alu = 1'b0;
      end
      OPC_INVTLB: begin
        w_alu                   = 1'b0;
        o_result.aluop          = EXE_INVTLB_OP;
        o_result.alusel         = EXE_RES_PRIV;
        o_result.reg_read_valid = 2'b11;
        o_result.reg_read_addr  = {w_rk, w_rj};
        o_result.use_imm        = 1'b1;
        o_result.imm            = {{(DATA_WIDTH-REG_AW){1'b0}}, w_rd};
        o_result.is_pri         = 1'b1;
      end
      default: begin
        // Unknown opcode: everything cleared except pc, which the INE handler needs
        w_alu    = 1'b0;
        o_result = '0;
        o_result.pc = i_info.pc;
      end
    endcase
    if (w_alu) begin
      o_result.reg_read_valid  = 2'b11;
      o_result.reg_read_addr   = {w_rk, w_rj};
      o_result.reg_write_valid = 1'b1;
      o_result.reg_write_addr  = w_rd;
    end
  end

endmodule

// File: rtl/decoder_3r_stage.sv
// Multi-lane registered decode stage for 3R instructions; privileged ops go alone in lane 0.
// Latency: 1 cycle from acceptance to out_valid_o.
// Backpressure: whole output group holds while out_ready_i is low; consumed_o drops to 0.
module decoder_3r_stage
  import decoder_3r_stage_pkg::*;
#(
  parameter int DECODE_WIDTH      = 2,
  parameter bit NEMU_STOP_SYSCALL = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush_i,
  input  logic [DECODE_WIDTH-1:0]                instr_valid_i,
  input  instr_buffer_info_t [DECODE_WIDTH-1:0]  instr_info_i,
  output logic [$clog2(DECODE_WIDTH+1)-1:0]      consumed_o,
  output logic [DECODE_WIDTH-1:0]                out_valid_o,
  output decode_3r_result_t [DECODE_WIDTH-1:0]   out_result_o,
  input  logic                                   out_ready_i,
  output logic [31:0]                            stall_cnt_o
);

  decode_3r_result_t [DECODE_WIDTH-1:0]  w_dec;
  logic [DECODE_WIDTH-1:0]               w_take;
  logic [$clog2(DECODE_WIDTH+1)-1:0]     w_n;
  logic                                  w_stop;
  logic                                  w_advance;

  logic [DECODE_WIDTH-1:0]               r_out_valid;
  decode_3r_result_t [DECODE_WIDTH-1:0]  r_out_result;
  logic [31:0]                           r_stall_cnt;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    decoder_3r_lane #(
      .NEMU_STOP_SYSCALL(NEMU_STOP_SYSCALL)
    ) u_lane (
      .i_info  (instr_info_i[g]),
      .o_result(w_dec[g])
    );
  end

  assign w_advance = !(|r_out_valid) || out_ready_i;

  // Take the leading run of valid lanes; a privileged op ends the group (alone if in lane 0)
  always_comb begin
    w_take = '0;
    w_n    = '0;
    w_stop = 1'b0;
    if (w_advance && !flush_i && !rst) begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (!w_stop) begin
          if (instr_valid_i[i] && ((i == 0) || !w_dec[i].is_pri)) begin
            w_take[i] = 1'b1;
            w_n       = w_n + 1'b1;
            if (w_dec[i].is_pri) w_stop = 1'b1;
          end else begin
            w_stop = 1'b1;
          end
        end
      end
    end
  end

  // Output group register: flush drops it, advance reloads it, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= '0;
      r_out_result <= '0;
    end else if (flush_i) begin
      r_out_valid  <= '0;
      r_out_result <= '0;
    end else if (w_advance) begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        r_out_valid[i]  <= w_take[i];
        r_out_result[i] <= w_take[i] ? w_dec[i] : '0;
      end
    end
  end

  // Saturating count of cycles where a valid group was refused downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((|r_out_valid) && !out_ready_i && !flush_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign consumed_o   = w_n;
  assign out_valid_o  = r_out_valid;
  assign out_result_o = r_out_result;
  assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_decoder_3r_stage.sv
// Directed bench for decoder_3r_stage: reset, dual issue, serialisation, stalls, flush.
// Latency: checks registered outputs 1 cycle after acceptance.
// Backpressure: exercises out_ready_i low for several cycles and flush during a stall.
module tb_decoder_3r_stage;
  import decoder_3r_stage_pkg::*;

  localparam logic [31:0] I_ADD    = 32'h00100823; // add.w r3,r1,r2
  localparam logic [31:0] I_SUB    = 32'h00110C44; // sub.w r4,r2,r3
  localparam logic [31:0] I_BRK    = 32'h002A0000;
  localparam logic [31:0] I_NEMU   = 32'h002B0011;
  localparam logic [31:0] I_SYS    = 32'h002B0005;
  localparam logic [31:0] I_ILL    = 32'hFFFF8000;
  localparam logic [31:0] I_DBAR   = 32'h38720000;
  localparam logic [31:0] I_INVTLB = 32'h06498825; // invtlb op=5, rj=r1, rk=r2

  logic                         clk;
  logic                         rst;
  logic                         flush_i;
  logic [1:0]                   instr_valid_i;
  instr_buffer_info_t [1:0]     instr_info_i;
  logic [1:0]                   consumed_o;
  logic [1:0]                   out_valid_o;
  decode_3r_result_t [1:0]      out_result_o;
  logic                         out_ready_i;
  logic [31:0]                  stall_cnt_o;

  int checks = 0;
  int errors = 0;

  decoder_3r_stage #(
    .DECODE_WIDTH     (2),
    .NEMU_STOP_SYSCALL(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .instr_valid_i(instr_valid_i),
    .instr_info_i (instr_info_i),
    .consumed_o   (consumed_o),
    .out_valid_o  (out_valid_o),
    .out_result_o (out_result_o),
    .out_ready_i  (out_ready_i),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] w0, input logic [31:0] w1);
    instr_valid_i         = v;
    instr_info_i[0].instr = w0;
    instr_info_i[0].pc    = 32'h1C00_0000;
    instr_info_i[1].instr = w1;
    instr_info_i[1].pc    = 32'h1C00_0004;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(2'b11, I_ADD, I_SUB);
    step(); step();
    checks++; if (consumed_o !== 2'd0) begin errors++; $display("FAIL reset_consumed got=%0d exp=0", consumed_o); end
    checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", out_valid_o); end
    checks++; if (out_result_o !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", out_result_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_dual_alu();
    out_ready_i = 1'b1;
    drive(2'b11, I_ADD, I_SUB);
    #1;
    checks++; if (consumed_o !== 2'd2) begin errors++; $display("FAIL dual_consumed got=%0d exp=2", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b11) begin errors++; $display("FAIL dual_valid got=%b exp=11", out_valid_o); end
    checks++; if (out_result_o[0].aluop !== EXE_ADD_OP) begin errors++; $display("FAIL dual_l0_aluop got=%h exp=%h", out_result_o[0].aluop, EXE_ADD_OP); end
    checks++; if (out_result_o[0].reg_write_addr !== 5'd3) begin errors++; $display("FAIL dual_l0_waddr got=%0d exp=3", out_result_o[0].reg_write_addr); end
    checks++; if (out_result_o[0].reg_read_addr !== {5'd2, 5'd1}) begin errors++; $display("FAIL dual_l0_raddr got=%h exp=%h", out_result_o[0].reg_read_addr, {5'd2, 5'd1}); end
    checks++; if (out_result_o[0].reg_read_valid !== 2'b11 || out_result_o[0].reg_write_valid !== 1'b1) begin errors++; $display("FAIL dual_l0_rwvalid got=%b/%b exp=11/1", out_result_o[0].reg_read_valid, out_result_o[0].reg_write_valid); end
    checks++; if (out_result_o[0].pc !== 32'h1C00_0000) begin errors++; $display("FAIL dual_l0_pc got=%h exp=1c000000", out_result_o[0].pc); end
    checks++; if (out_result_o[1].aluop !== EXE_SUB_OP) begin errors++; $display("FAIL dual_l1_aluop got=%h exp=%h", out_result_o[1].aluop, EXE_SUB_OP); end
    checks++; if (out_result_o[1].reg_write_addr !== 5'd4) begin errors++; $display("FAIL dual_l1_waddr got=%0d exp=4", out_result_o[1].reg_write_addr); end
    checks++; if (out_result_o[1].reg_read_addr !== {5'd3, 5'd2}) begin errors++; $display("FAIL dual_l1_raddr got=%h exp=%h", out_result_o[1].reg_read_addr, {5'd3, 5'd2}); end
    drive(2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_pri_serial();
    out_ready_i = 1'b1;
    drive(2'b11, I_ADD, I_BRK);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL pri_trunc_consumed got=%0d exp=1", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL pri_trunc_valid got=%b exp=01", out_valid_o); end
    checks++; if (out_result_o[1] !== '0) begin errors++; $display("FAIL pri_trunc_l1_zero got=%h exp=0", out_result_o[1]); end
    drive(2'b11, I_BRK, I_ADD);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL pri_l0_consumed got=%0d exp=1", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL pri_l0_valid got=%b exp=01", out_valid_o); end
    checks++; if (out_result_o[0].instr_break !== 1'b1) begin errors++; $display("FAIL pri_break got=%b exp=1", out_result_o[0].instr_break); end
    checks++; if (out_result_o[0].reg_read_valid !== 2'b00) begin errors++; $display("FAIL pri_rvalid got=%b exp=00", out_result_o[0].reg_read_valid); end
    checks++; if (out_result_o[0].is_pri !== 1'b1 || out_result_o[0].not_commit_instr !== 1'b1) begin errors++; $display("FAIL pri_flags got=%b/%b exp=1/1", out_result_o[0].is_pri, out_result_o[0].not_commit_instr); end
    drive(2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_nemu_stop();
    out_ready_i = 1'b1;
    drive(2'b11, I_NEMU, I_ADD);
    #1;
    checks++; if (consumed_o !== 2'd2) begin errors++; $display("FAIL nemu_consumed got=%0d exp=2", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b11) begin errors++; $display("FAIL nemu_valid got=%b exp=11", out_valid_o); end
    checks++; if (out_result_o[0].instr_syscall !== 1'b0 || out_result_o[0].is_pri !== 1'b0) begin errors++; $display("FAIL nemu_flags got=%b/%b exp=0/0", out_result_o[0].instr_syscall, out_result_o[0].is_pri); end
    checks++; if (out_result_o[0].decode_valid !== 1'b1) begin errors++; $display("FAIL nemu_dvalid got=%b exp=1", out_result_o[0].decode_valid); end
    drive(2'b11, I_ADD, I_SYS);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL sys_trunc_consumed got=%0d exp=1", consumed_o); end
    step();
    drive(2'b11, I_SYS, I_ADD);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL sys_l0_consumed got=%0d exp=1", consumed_o); end
    step();
    checks++; if (out_result_o[0].instr_syscall !== 1'b1 || out_result_o[0].is_pri !== 1'b1) begin errors++; $display("FAIL sys_flags got=%b/%b exp=1/1", out_result_o[0].instr_syscall, out_result_o[0].is_pri); end
    drive(2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b1;
    drive(2'b11, I_ADD, I_SUB);
    step();
    out_ready_i = 1'b0;
    drive(2'b11, I_SUB, I_ADD);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (consumed_o !== 2'd0) begin errors++; $display("FAIL bp_consumed[%0d] got=%0d exp=0", k, consumed_o); end
      checks++; if (out_valid_o !== 2'b11 || out_result_o[0].aluop !== EXE_ADD_OP || out_result_o[1].aluop !== EXE_SUB_OP) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%h exp=11/%h/%h", k, out_valid_o, out_result_o[0].aluop, out_result_o[1].aluop, EXE_ADD_OP, EXE_SUB_OP); end
      step();
    end
    checks++; if (stall_cnt_o !== 32'd5) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt_o); end
  endtask

  task automatic test_flush();
    // Continues the stall left by test_backpressure
    flush_i = 1'b1;
    #1;
    checks++; if (consumed_o !== 2'd0) begin errors++; $display("FAIL flush_consumed got=%0d exp=0", consumed_o); end
    step();
    flush_i = 1'b0;
    checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", out_valid_o); end
    checks++; if (stall_cnt_o !== 32'd5) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=5", stall_cnt_o); end
    #1;
    checks++; if (consumed_o !== 2'd2) begin errors++; $display("FAIL flush_next_consumed got=%0d exp=2", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b11 || out_result_o[0].aluop !== EXE_SUB_OP) begin errors++; $display("FAIL flush_next_group got=%b/%h exp=11/%h", out_valid_o, out_result_o[0].aluop, EXE_SUB_OP); end
    out_ready_i = 1'b1;
    drive(2'b00, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_illegal();
    out_ready_i = 1'b1;
    drive(2'b01, I_ILL, 32'h0);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL ill_consumed got=%0d exp=1", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL ill_valid got=%b exp=01", out_valid_o); end
    checks++; if (out_result_o[0].decode_valid !== 1'b0 || out_result_o[0].reg_write_valid !== 1'b0) begin errors++; $display("FAIL ill_dvalid_wvalid got=%b/%b exp=0/0", out_result_o[0].decode_valid, out_result_o[0].reg_write_valid); end
    checks++; if (out_result_o[0].aluop !== 8'h00 || out_result_o[0].is_pri !== 1'b0) begin errors++; $display("FAIL ill_aluop_pri got=%h/%b exp=00/0", out_result_o[0].aluop, out_result_o[0].is_pri); end
    drive(2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_stall();
    out_ready_i = 1'b1;
    drive(2'b11, I_ADD, I_SUB);
    step();
    out_ready_i = 1'b0;
    step(); step();
    checks++; if (stall_cnt_o !== 32'd7) begin errors++; $display("FAIL rst_stall_pre got=%0d exp=7", stall_cnt_o); end
    rst = 1'b1;
    #1;
    checks++; if (consumed_o !== 2'd0) begin errors++; $display("FAIL rst_stall_consumed got=%0d exp=0", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b00 || stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_stall_clear got=%b/%0d exp=00/0", out_valid_o, stall_cnt_o); end
    rst = 1'b0;
    out_ready_i = 1'b1;
    drive(2'b00, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    drive(2'b11, I_DBAR, I_INVTLB);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL b2b_dbar_consumed got=%0d exp=1", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b01 || out_result_o[0].decode_valid !== 1'b1 || out_result_o[0].aluop !== EXE_NOP_OP || out_result_o[0].reg_read_valid !== 2'b00) begin errors++; $display("FAIL b2b_dbar got=%b/%b/%h/%b exp=01/1/00/00", out_valid_o, out_result_o[0].decode_valid, out_result_o[0].aluop, out_result_o[0].reg_read_valid); end
    drive(2'b11, I_INVTLB, I_ADD);
    #1;
    checks++; if (consumed_o !== 2'd1) begin errors++; $display("FAIL b2b_invtlb_consumed got=%0d exp=1", consumed_o); end
    step();
    checks++; if (out_result_o[0].imm !== 32'd5 || out_result_o[0].reg_read_valid !== 2'b11 || out_result_o[0].reg_read_addr !== {5'd2, 5'd1}) begin errors++; $display("FAIL b2b_invtlb_read got=%h/%b/%h exp=5/11/%h", out_result_o[0].imm, out_result_o[0].reg_read_valid, out_result_o[0].reg_read_addr, {5'd2, 5'd1}); end
    checks++; if (out_result_o[0].reg_write_valid !== 1'b0 || out_result_o[0].is_pri !== 1'b1) begin errors++; $display("FAIL b2b_invtlb_flags got=%b/%b exp=0/1", out_result_o[0].reg_write_valid, out_result_o[0].is_pri); end
    drive(2'b11, I_ADD, I_SUB);
    #1;
    checks++; if (consumed_o !== 2'd2) begin errors++; $display("FAIL b2b_alu_consumed got=%0d exp=2", consumed_o); end
    step();
    checks++; if (out_valid_o !== 2'b11) begin errors++; $display("FAIL b2b_alu_valid got=%b exp=11", out_valid_o); end
    drive(2'b00, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    test_reset();
    test_dual_alu();
    test_pri_serial();
    test_nemu_stop();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
